alu_shift_sequencer: RTL and testbench

ALU_SHIFT_SEQUENCER -- requirements
Module: alu_shift_sequencer

---
 rtl/alu_shift_sequencer.sv | 94 +++++++++
 tb/tb_alu_shift_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// Sequences an N-bit logical shift as N single-step requests to an external
// registered shift unit, with valid/ready handshakes on command and result.
module alu_shift_sequencer #(
  parameter int Op_Width  = 16,
  parameter int Amt_Width = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Cmd_Valid,
  output logic                 Cmd_Ready,
  input  logic [Op_Width-1:0]  Cmd_Data,
  input  logic                 Cmd_Dir,
  input  logic [Amt_Width-1:0] Cmd_Amt,
  output logic [Op_Width-1:0]  Su_A,
  output logic [Op_Width-1:0]  Su_B,
  output logic [1:0]           Su_FUN,
  output logic                 Su_En,
  input  logic [Op_Width-1:0]  Su_Out,
  input  logic                 Su_Flag,
  output logic                 Res_Valid,
  input  logic                 Res_Ready,
  output logic [Op_Width-1:0]  Res_Data,
  output logic                 Res_Err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [Op_Width-1:0]   work_q, work_d;
  logic [Amt_Width-1:0]  remaining_q, remaining_d;
  logic                  dir_q, dir_d;
  logic                  err_q, err_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      work_q      <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (Cmd_Valid) begin
          work_d      = Cmd_Data;
          dir_d       = Cmd_Dir;
          remaining_d = Cmd_Amt;
          err_d       = 1'b0;
          state_d     = (Cmd_Amt == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A missing flag aborts the chain and returns the last good value.
        if (Su_Flag) begin
          work_d      = Su_Out;
          remaining_d = remaining_q - Amt_Width'(1);
          state_d     = (remaining_q == Amt_Width'(1)) ? DONE : ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (Res_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Cmd_Ready = (state_q == IDLE);
  assign Su_En     = (state_q == ISSUE);
  assign Su_A      = work_q;
  assign Su_B      = '0;
  assign Su_FUN    = {1'b0, dir_q};
  assign Res_Valid = (state_q == DONE);
  assign Res_Data  = work_q;
  assign Res_Err   = err_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a one-step registered shift-unit model.
module tb_alu_shift_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Dir;
  logic [15:0] Cmd_Data;
  logic [3:0]  Cmd_Amt;
  logic [15:0] Su_A, Su_B, Su_Out;
  logic [1:0]  Su_FUN;
  logic        Su_En, Su_Flag;
  logic        Res_Valid, Res_Ready, Res_Err;
  logic [15:0] Res_Data;

  logic        fail_flag;
  int          en_cnt;
  logic [15:0] su_a_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    logic [15:0] data;
    logic        dir;
    logic [3:0]  amt;
    logic        hold;
    logic [15:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  alu_shift_sequencer #(.Op_Width(16), .Amt_Width(4)) dut (
    .CLK(CLK), .RST(RST),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Data(Cmd_Data),
    .Cmd_Dir(Cmd_Dir), .Cmd_Amt(Cmd_Amt),
    .Su_A(Su_A), .Su_B(Su_B), .Su_FUN(Su_FUN), .Su_En(Su_En),
    .Su_Out(Su_Out), .Su_Flag(Su_Flag),
    .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Res_Data(Res_Data), .Res_Err(Res_Err)
  );

  always #5 CLK = ~CLK;

  // Shift unit: one registered single-bit step per enable.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Su_Flag <= 1'b0;
      Su_Out  <= '0;
    end else begin
      Su_Flag <= Su_En & ~fail_flag;
      if (Su_En) Su_Out <= (Su_FUN == 2'b01) ? (Su_A << 1) : (Su_A >> 1);
    end
  end

  always @(negedge CLK) begin
    if (Su_En) begin
      en_cnt = en_cnt + 1;
      su_a_log.push_back(Su_A);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input logic [15:0] data, input logic dir, input logic [3:0] amt,
                        input logic hold, input logic [15:0] exp_data, input logic exp_err,
                        input int exp_lat, input int exp_pulses);
    int lat;
    bit seen;
    @(negedge CLK);
    check("cmd_ready_idle", 32'(Cmd_Ready), 32'd1);
    en_cnt = 0;
    su_a_log.delete();
    Cmd_Valid = 1'b1; Cmd_Data = data; Cmd_Dir = dir; Cmd_Amt = amt;
    @(posedge CLK); #1;
    if (hold) begin
      Cmd_Data = 16'h0001; Cmd_Dir = 1'b0; Cmd_Amt = 4'd0;
    end else begin
      Cmd_Valid = 1'b0;
    end
    lat = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge CLK);
      lat++;
      check("cmd_ready_busy", 32'(Cmd_Ready), 32'd0);
      if (Res_Valid) seen = 1;
    end
    Cmd_Valid = 1'b0;
    check("latency", seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
    check("res_data", 32'(Res_Data), 32'(exp_data));
    check("res_err", 32'(Res_Err), 32'(exp_err));
    check("su_en_pulses", 32'(en_cnt), 32'(exp_pulses));
  endtask

  task automatic consume();
    @(negedge CLK);
    check("cmd_ready_after", 32'(Cmd_Ready), 32'd1);
    check("res_valid_after", 32'(Res_Valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h8001, 1'b1, 4'd1,  1'b0, 16'h0002, 3};
    vecs[1] = '{16'hF0F0, 1'b0, 4'd4,  1'b0, 16'h0F0F, 9};
    vecs[2] = '{16'h1234, 1'b0, 4'd0,  1'b0, 16'h1234, 1};
    vecs[3] = '{16'hFFFF, 1'b1, 4'd15, 1'b1, 16'h8000, 31};
    vecs[4] = '{16'hA5A5, 1'b0, 4'd8,  1'b0, 16'h00A5, 17};
    vecs[5] = '{16'h0001, 1'b1, 4'd15, 1'b0, 16'h8000, 31};
    vecs[6] = '{16'h8000, 1'b0, 4'd15, 1'b0, 16'h0001, 31};
    vecs[7] = '{16'hC3C3, 1'b1, 4'd2,  1'b0, 16'h0F0C, 5};

    RST = 1'b0; Cmd_Valid = 1'b0; Cmd_Data = '0; Cmd_Dir = 1'b0; Cmd_Amt = '0;
    Res_Ready = 1'b0; fail_flag = 1'b0; en_cnt = 0;
    #12;
    check("rst_cmd_ready", 32'(Cmd_Ready), 32'd1);
    check("rst_res_valid", 32'(Res_Valid), 32'd0);
    check("rst_res_data", 32'(Res_Data), 32'd0);
    check("rst_res_err", 32'(Res_Err), 32'd0);
    check("rst_su_en", 32'(Su_En), 32'd0);
    check("rst_su_a", 32'(Su_A), 32'd0);
    check("rst_su_b", 32'(Su_B), 32'd0);
    check("rst_su_fun", 32'(Su_FUN), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    Res_Ready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].data, vecs[i].dir, vecs[i].amt, vecs[i].hold, vecs[i].exp,
             1'b0, vecs[i].lat, int'(vecs[i].amt));
      if (i == 1) begin
        check("su_a_count", 32'(su_a_log.size()), 32'd4);
        if (su_a_log.size() == 4) begin
          check("su_a_0", 32'(su_a_log[0]), 32'h0000_F0F0);
          check("su_a_1", 32'(su_a_log[1]), 32'h0000_7878);
          check("su_a_2", 32'(su_a_log[2]), 32'h0000_3C3C);
          check("su_a_3", 32'(su_a_log[3]), 32'h0000_1E1E);
        end
      end
      consume();
    end

    // Result back-pressure for 5 cycles
    Res_Ready = 1'b0;
    run_op(16'h00FF, 1'b1, 4'd4, 1'b0, 16'h0FF0, 1'b0, 9, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check("bp_res_valid", 32'(Res_Valid), 32'd1);
      check("bp_res_data", 32'(Res_Data), 32'h0000_0FF0);
      check("bp_cmd_ready", 32'(Cmd_Ready), 32'd0);
    end
    Res_Ready = 1'b1;
    consume();

    // Shift unit never returns its flag
    fail_flag = 1'b1;
    run_op(16'h5A5A, 1'b1, 4'd3, 1'b0, 16'h5A5A, 1'b1, 3, 1);
    consume();
    fail_flag = 1'b0;
    run_op(16'h5A5A, 1'b1, 4'd3, 1'b0, 16'hD2D0, 1'b0, 7, 3);
    consume();

    // Reset in WAIT of an Amt = 3 operation
    @(negedge CLK);
    Cmd_Valid = 1'b1; Cmd_Data = 16'h0F00; Cmd_Dir = 1'b1; Cmd_Amt = 4'd3;
    @(posedge CLK); #1;
    Cmd_Valid = 1'b0;
    @(negedge CLK);
    check("mid_su_en_issue", 32'(Su_En), 32'd1);
    @(negedge CLK);
    check("mid_su_fun_wait", 32'(Su_FUN), 32'd1);
    #2 RST = 1'b0;
    #1;
    check("arst_cmd_ready", 32'(Cmd_Ready), 32'd1);
    check("arst_res_valid", 32'(Res_Valid), 32'd0);
    check("arst_res_data", 32'(Res_Data), 32'd0);
    check("arst_res_err", 32'(Res_Err), 32'd0);
    check("arst_su_en", 32'(Su_En), 32'd0);
    check("arst_su_a", 32'(Su_A), 32'd0);
    check("arst_su_fun", 32'(Su_FUN), 32'd0);
    @(negedge CLK);
    check("arst_no_result", 32'(Res_Valid), 32'd0);
    RST = 1'b1;
    run_op(16'h0003, 1'b1, 4'd2, 1'b0, 16'h000C, 1'b0, 5, 2);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
